// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: decodes 32-bit command words into register-bus transactions.
// Optional STATUS opcode (4'h1) is compiled in when SPI_CMD_STATUS_EN is defined.
module spi_cmd_ctrl #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [15:0] ERR_WORD = 16'hDEAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_data,
    input  logic        cmd_ready,
    output logic [15:0] read_out,
    output logic [11:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, DECODE, WRITE, READ, DONE} state_t;

    localparam logic [3:0]  OP_WRITE = 4'h8;
    localparam logic [3:0]  OP_READ  = 4'h4;
    localparam logic [3:0]  OP_CLR   = 4'h2;
`ifdef SPI_CMD_STATUS_EN
    localparam logic [3:0]  OP_STATUS = 4'h1;
`endif
    localparam logic [15:0] TO_LIM   = 16'(TIMEOUT);

    state_t      state, state_d;
    logic        rdy_q;
    logic        take;
    logic [31:0] cmd_q;
    logic [15:0] tmr;
    logic [3:0]  to_cnt, ill_cnt, ovr_cnt;
    logic [3:0]  op;

    assign take = cmd_ready & ~rdy_q;
    assign busy = (state != IDLE);
    assign op   = cmd_q[31:28];

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (take) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_WRITE: state_d = WRITE;
                    OP_READ:  state_d = READ;
                    default:  state_d = DONE;
                endcase
            end
            WRITE, READ: if (bus_ack || (tmr == TO_LIM)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q     <= 1'b0;
            cmd_q     <= '0;
            tmr       <= '0;
            read_out  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            err       <= 1'b0;
            to_cnt    <= '0;
            ill_cnt   <= '0;
            ovr_cnt   <= '0;
        end else begin
            rdy_q <= cmd_ready;
            if (take && busy) ovr_cnt <= sat_inc(ovr_cnt);
            case (state)
                IDLE: if (take) cmd_q <= cmd_data;
                DECODE: begin
                    tmr <= '0;
                    case (op)
                        OP_WRITE: begin
                            bus_addr  <= cmd_q[27:16];
                            bus_wdata <= cmd_q[15:0];
                            bus_we    <= 1'b1;
                        end
                        OP_READ: begin
                            bus_addr <= cmd_q[27:16];
                            bus_re   <= 1'b1;
                        end
                        // Placed after the overrun update so a clear in the same cycle wins.
                        OP_CLR: begin
                            err     <= 1'b0;
                            to_cnt  <= '0;
                            ill_cnt <= '0;
                            ovr_cnt <= '0;
                        end
`ifdef SPI_CMD_STATUS_EN
                        OP_STATUS: read_out <= {err, 3'b000, to_cnt, ill_cnt, ovr_cnt};
`endif
                        default: begin
                            read_out <= ERR_WORD;
                            err      <= 1'b1;
                            ill_cnt  <= sat_inc(ill_cnt);
                        end
                    endcase
                end
                WRITE, READ: begin
                    if (bus_ack) begin
                        read_out <= (state == READ) ? bus_rdata : bus_wdata;
                        bus_we   <= 1'b0;
                        bus_re   <= 1'b0;
                    end else if (tmr == TO_LIM) begin
                        read_out <= ERR_WORD;
                        err      <= 1'b1;
                        to_cnt   <= sat_inc(to_cnt);
                        bus_we   <= 1'b0;
                        bus_re   <= 1'b0;
                    end else begin
                        tmr <= tmr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed scenarios plus randomized commands
// checked against a transaction-level model of results, flags and counters.
module tb_spi_cmd_ctrl;

    localparam int unsigned TO   = 4;
    localparam logic [15:0] ERRW = 16'hDEAD;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [15:0] read_out;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we, bus_re, bus_ack;
    logic [15:0] bus_rdata;
    logic        busy, err;

    int checks = 0;
    int errors = 0;

    spi_cmd_ctrl #(.TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .read_out(read_out), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Transaction-level model state
    logic        m_err;
    int          m_to, m_ill, m_ovr;
    logic [15:0] m_rd;

    // Observations from the last run_cmd
    int          o_nstb, o_first, o_idle;
    logic        o_we, o_re, o_done_set;
    logic [11:0] o_addr;
    logic [15:0] o_wdata, o_rd_done;

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        m_err = 1'b0; m_to = 0; m_ill = 0; m_ovr = 0; m_rd = 16'h0000;
    endtask

    // Returns expected strobe length and the cycle at which busy is first seen low.
    task automatic model_cmd(input logic [31:0] cmd, input int lat, input logic [15:0] rdata,
                             input bit ovr, output int nstb, output int idle);
        nstb = 0;
        if (cmd[31:28] == 4'h8 || cmd[31:28] == 4'h4) begin
            if (lat <= int'(TO)) begin
                nstb = lat + 1;
                m_rd = (cmd[31:28] == 4'h8) ? cmd[15:0] : rdata;
            end else begin
                nstb = TO + 1;
                m_rd = ERRW; m_err = 1'b1; m_to = sat15(m_to + 1);
            end
            if (ovr) m_ovr = sat15(m_ovr + 1);
        end else if (cmd[31:28] == 4'h2) begin
            m_err = 1'b0; m_to = 0; m_ill = 0; m_ovr = 0;
`ifdef SPI_CMD_STATUS_EN
        end else if (cmd[31:28] == 4'h1) begin
            m_rd = {m_err, 3'b000, 4'(m_to), 4'(m_ill), 4'(m_ovr)};
`endif
        end else begin
            m_rd = ERRW; m_err = 1'b1; m_ill = sat15(m_ill + 1);
        end
        idle = (nstb > 0) ? nstb + 3 : 3;
    endtask

    // Issues one command and acts as bus responder; ack on strobe cycle lat+1.
    task automatic run_cmd(input logic [31:0] cmd, input int lat, input logic [15:0] rdata,
                           input int ovr_at, input logic [31:0] cmd2, input logic stray);
        int cyc;
        o_nstb = 0; o_first = -1; o_idle = -1; o_we = 1'b0; o_re = 1'b0;
        o_addr = '0; o_wdata = '0; o_rd_done = '0; o_done_set = 1'b0;
        @(posedge clk); #1;
        cmd_data = cmd; cmd_ready = 1'b1; bus_ack = 1'b0;
        cyc = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            cyc++;
            cmd_ready = 1'b0;
            if (!busy) begin
                o_idle = cyc;
                break;
            end
            if (bus_we || bus_re) begin
                if (o_first < 0) o_first = cyc;
                o_nstb++;
                o_we = o_we | bus_we;
                o_re = o_re | bus_re;
                o_addr = bus_addr;
                o_wdata = bus_wdata;
                bus_ack = (o_nstb == lat + 1);
                bus_rdata = rdata;
                if (ovr_at == o_nstb) begin
                    cmd_data = cmd2;
                    cmd_ready = 1'b1;
                end
            end else begin
                if (o_nstb > 0 && !o_done_set) begin
                    o_rd_done = read_out;
                    o_done_set = 1'b1;
                end
                bus_ack = stray;
                bus_rdata = ~rdata;
            end
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_data = '0; cmd_ready = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({read_out, bus_addr, bus_wdata, bus_we, bus_re, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ro=%h addr=%h wd=%h we=%b re=%b busy=%b err=%b exp all zero",
                     read_out, bus_addr, bus_wdata, bus_we, bus_re, busy, err);
        end
        checks++;
        if ({dut.to_cnt, dut.ill_cnt, dut.ovr_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_counters: got %h exp 000", {dut.to_cnt, dut.ill_cnt, dut.ovr_cnt});
        end
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        int n, idle;
        run_cmd(32'h8C8C8C8A, 0, 16'h0000, 0, '0, 1'b0);
        model_cmd(32'h8C8C8C8A, 0, 16'h0000, 1'b0, n, idle);
        checks++;
        if (o_first !== 2 || o_nstb !== 1 || o_we !== 1'b1 || o_re !== 1'b0) begin
            errors++;
            $display("FAIL wr_strobe: got first=%0d n=%0d we=%b re=%b exp first=2 n=1 we=1 re=0",
                     o_first, o_nstb, o_we, o_re);
        end
        checks++;
        if (o_addr !== 12'hC8C || o_wdata !== 16'h8C8A) begin
            errors++;
            $display("FAIL wr_bus: got addr=%h wdata=%h exp C8C 8C8A", o_addr, o_wdata);
        end
        checks++;
        if (o_rd_done !== 16'h8C8A || err !== 1'b0) begin
            errors++;
            $display("FAIL wr_result: got ro=%h err=%b exp 8c8a 0", o_rd_done, err);
        end
        checks++;
        if (o_idle !== 4) begin
            errors++;
            $display("FAIL wr_busy_drop: got cycle %0d exp 4", o_idle);
        end
    endtask

    task automatic test_read_latency();
        int n, idle;
        run_cmd(32'h4012_0000, 2, 16'hA3A3, 0, '0, 1'b0);
        model_cmd(32'h4012_0000, 2, 16'hA3A3, 1'b0, n, idle);
        checks++;
        if (o_nstb !== 3 || o_re !== 1'b1 || o_we !== 1'b0 || o_addr !== 12'h012) begin
            errors++;
            $display("FAIL rd_strobe: got n=%0d re=%b we=%b addr=%h exp 3 1 0 012", o_nstb, o_re, o_we, o_addr);
        end
        checks++;
        if (read_out !== 16'hA3A3 || err !== 1'b0 || o_idle !== 6) begin
            errors++;
            $display("FAIL rd_result: got ro=%h err=%b idle=%0d exp a3a3 0 6", read_out, err, o_idle);
        end
    endtask

    task automatic test_timeout();
        int n, idle;
        run_cmd(32'h4FFF_0000, 100, 16'h5555, 0, '0, 1'b0);
        model_cmd(32'h4FFF_0000, 100, 16'h5555, 1'b0, n, idle);
        checks++;
        if (o_nstb !== 5 || o_idle !== 8) begin
            errors++;
            $display("FAIL to_strobe: got n=%0d idle=%0d exp 5 8", o_nstb, o_idle);
        end
        checks++;
        if (read_out !== 16'hDEAD || err !== 1'b1 || dut.to_cnt !== 4'd1) begin
            errors++;
            $display("FAIL to_result: got ro=%h err=%b to=%0d exp dead 1 1", read_out, err, dut.to_cnt);
        end
        // ack on the very cycle the timeout would fire: ack wins
        run_cmd(32'h4ABC_0000, TO, 16'h7E57, 0, '0, 1'b0);
        model_cmd(32'h4ABC_0000, TO, 16'h7E57, 1'b0, n, idle);
        checks++;
        if (read_out !== 16'h7E57 || dut.to_cnt !== 4'd1 || o_nstb !== 5) begin
            errors++;
            $display("FAIL ack_vs_to: got ro=%h to=%0d n=%0d exp 7e57 1 5", read_out, dut.to_cnt, o_nstb);
        end
    endtask

    task automatic test_overrun_illegal();
        int n, idle;
        run_cmd(32'h4055_0000, 3, 16'h1234, 2, 32'h8777_5555, 1'b0);
        model_cmd(32'h4055_0000, 3, 16'h1234, 1'b1, n, idle);
        checks++;
        if (dut.ovr_cnt !== 4'd1 || o_we !== 1'b0 || read_out !== 16'h1234 || o_addr !== 12'h055) begin
            errors++;
            $display("FAIL overrun: got ovr=%0d we=%b ro=%h addr=%h exp 1 0 1234 055",
                     dut.ovr_cnt, o_we, read_out, o_addr);
        end
        checks++;
        if (o_idle !== 7) begin
            errors++;
            $display("FAIL overrun_idle: got %0d exp 7", o_idle);
        end
        run_cmd(32'hF000_0000, 0, 16'h0000, 0, '0, 1'b1);
        model_cmd(32'hF000_0000, 0, 16'h0000, 1'b0, n, idle);
        checks++;
        if (read_out !== 16'hDEAD || dut.ill_cnt !== 4'd1 || o_nstb !== 0 || o_idle !== 3) begin
            errors++;
            $display("FAIL illegal: got ro=%h ill=%0d n=%0d idle=%0d exp dead 1 0 3",
                     read_out, dut.ill_cnt, o_nstb, o_idle);
        end
    endtask

    task automatic test_status_clear();
        int n, idle;
        logic [15:0] exp_st;
`ifdef SPI_CMD_STATUS_EN
        exp_st = 16'h8111;
`else
        exp_st = 16'hDEAD;
`endif
        run_cmd(32'h1000_0000, 0, 16'h0000, 0, '0, 1'b0);
        model_cmd(32'h1000_0000, 0, 16'h0000, 1'b0, n, idle);
        checks++;
        if (read_out !== exp_st) begin
            errors++;
            $display("FAIL status: got %h exp %h", read_out, exp_st);
        end
        run_cmd(32'h2000_0000, 0, 16'h0000, 0, '0, 1'b0);
        model_cmd(32'h2000_0000, 0, 16'h0000, 1'b0, n, idle);
        checks++;
        if (err !== 1'b0 || {dut.to_cnt, dut.ill_cnt, dut.ovr_cnt} !== 12'h000 || read_out !== exp_st) begin
            errors++;
            $display("FAIL clear: got err=%b cnts=%h ro=%h exp 0 000 %h",
                     err, {dut.to_cnt, dut.ill_cnt, dut.ovr_cnt}, read_out, exp_st);
        end
    endtask

    task automatic test_reset_mid_write();
        int n, idle;
        @(posedge clk); #1;
        cmd_data = 32'h8ABC_1234; cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_we: got %b exp 1", bus_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({read_out, bus_addr, bus_wdata, bus_we, bus_re, busy, err} !== '0) begin
            errors++;
            $display("FAIL rst_async: got ro=%h addr=%h wd=%h we=%b re=%b busy=%b err=%b exp all zero",
                     read_out, bus_addr, bus_wdata, bus_we, bus_re, busy, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run_cmd(32'h8321_BEEF, 1, 16'h0000, 0, '0, 1'b0);
        model_cmd(32'h8321_BEEF, 1, 16'h0000, 1'b0, n, idle);
        checks++;
        if (read_out !== 16'hBEEF || o_addr !== 12'h321 || o_nstb !== 2 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_write: got ro=%h addr=%h n=%0d err=%b exp beef 321 2 0",
                     read_out, o_addr, o_nstb, err);
        end
    endtask

    task automatic test_saturation();
        int n, idle;
        for (int i = 0; i < 17; i++) begin
            run_cmd(32'hE000_0000, 0, 16'h0000, 0, '0, 1'b0);
            model_cmd(32'hE000_0000, 0, 16'h0000, 1'b0, n, idle);
        end
        checks++;
        if (dut.ill_cnt !== 4'd15 || err !== 1'b1) begin
            errors++;
            $display("FAIL ill_saturate: got ill=%0d err=%b exp 15 1", dut.ill_cnt, err);
        end
    endtask

    task automatic test_random();
        int n, idle, lat, ovr_at, r, exp_n;
        logic [31:0] cmd;
        logic [15:0] rdata;
        logic [3:0] op;
        logic stray;
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 4'h8 : (r < 6) ? 4'h4 : (r == 6) ? 4'h2 : (r == 7) ? 4'h1 : 4'($urandom);
            cmd = {op, 12'($urandom), 16'($urandom)};
            lat = $urandom_range(0, TO + 2);
            rdata = 16'($urandom);
            stray = 1'($urandom);
            exp_n = ((lat < int'(TO)) ? lat : int'(TO)) + 1;
            ovr_at = 0;
            if ((op == 4'h8 || op == 4'h4) && $urandom_range(0, 3) == 0) ovr_at = $urandom_range(1, exp_n);
            run_cmd(cmd, lat, rdata, ovr_at, 32'h8FFF_FFFF, stray);
            model_cmd(cmd, lat, rdata, ovr_at != 0, n, idle);
            checks++;
            if (o_nstb !== n || o_idle !== idle) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: cmd=%h got n=%0d idle=%0d exp n=%0d idle=%0d",
                         i, cmd, o_nstb, o_idle, n, idle);
            end
            checks++;
            if (read_out !== m_rd || err !== m_err) begin
                errors++;
                $display("FAIL rnd_result[%0d]: cmd=%h got ro=%h err=%b exp ro=%h err=%b",
                         i, cmd, read_out, err, m_rd, m_err);
            end
            checks++;
            if (dut.to_cnt !== 4'(m_to) || dut.ill_cnt !== 4'(m_ill) || dut.ovr_cnt !== 4'(m_ovr)) begin
                errors++;
                $display("FAIL rnd_counters[%0d]: got to=%0d ill=%0d ovr=%0d exp %0d %0d %0d",
                         i, dut.to_cnt, dut.ill_cnt, dut.ovr_cnt, m_to, m_ill, m_ovr);
            end
            checks++;
            if (o_we !== (op == 4'h8) || o_re !== (op == 4'h4) ||
                (n > 0 && (o_addr !== cmd[27:16] || o_first !== 2)) ||
                (op == 4'h8 && o_wdata !== cmd[15:0])) begin
                errors++;
                $display("FAIL rnd_bus[%0d]: cmd=%h got we=%b re=%b addr=%h wd=%h first=%0d",
                         i, cmd, o_we, o_re, o_addr, o_wdata, o_first);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_latency();
        test_timeout();
        test_overrun_illegal();
        test_status_clear();
        test_reset_mid_write();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
